fifo_serializer: RTL

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

---
 rtl/fifo_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_serializer.sv
// fifo_serializer: pulls up to READ entries from the head of a FIFO in one
// cycle, buffers them locally and hands them to a consumer one per cycle over
// a valid/ready interface. A refill is issued in the same cycle the last
// buffered entry is accepted, so back-to-back batches stream without a bubble.
module fifo_serializer #(
    parameter int   DATA = 32,
    parameter int   READ = 4,
    parameter logic ACT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_,
    input  logic [READ*DATA-1:0]   rd,
    input  logic [READ-1:0]        v,
    output logic [READ-1:0]        re,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA-1:0]        out_data,
    output logic [$clog2(READ):0]  pending
);

    localparam int PW = $clog2(READ);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   k;
    logic [DATA-1:0] buffer [READ];
    logic            transfer;
    logic            last;
    logic            load;
    logic [READ-1:0] grab;
    logic            run;

    // Count the unbroken run of valid lanes starting at lane 0; anything past
    // the first hole is left in the FIFO so entries stay in order.
    always_comb begin
        k   = '0;
        run = 1'b1;
        for (int i = 0; i < READ; i++) begin
            if (run && v[i]) begin
                k = k + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Decide whether this cycle fetches from the FIFO and which lanes it pops;
    // reset and flush both force every read enable to its inactive level.
    always_comb begin
        transfer = (state == DRAIN) && out_ready;
        last     = ({1'b0, ptr} == (cnt - CW'(1)));
        load     = flush_ && (k != '0) && ((state == IDLE) || (transfer && last));
        grab     = '0;
        re       = '0;
        for (int i = 0; i < READ; i++) begin
            grab[i] = load && (CW'(i) < k);
            re[i]   = (!reset && grab[i]) ? ACT : ~ACT;
        end
    end

    assign out_valid = (state == DRAIN);
    assign pending   = cnt - {1'b0, ptr};

    // Buffer fill/drain state machine; out_data is kept registered so it holds
    // the last shown entry once the buffer runs empty or is flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            out_data <= '0;
            for (int i = 0; i < READ; i++) begin
                buffer[i] <= '0;
            end
        end else if (!flush_) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
        end else if (load) begin
            for (int i = 0; i < READ; i++) begin
                if (grab[i]) begin
                    buffer[i] <= rd[i*DATA +: DATA];
                end
            end
            cnt      <= k;
            ptr      <= '0;
            state    <= DRAIN;
            out_data <= rd[DATA-1:0];
        end else if (transfer) begin
            if (last) begin
                state <= IDLE;
                cnt   <= '0;
                ptr   <= '0;
            end else begin
                ptr      <= ptr + PW'(1);
                out_data <= buffer[ptr + PW'(1)];
            end
        end
    end

endmodule
